// File: rtl/nibble_tx_pkg.sv
// nibble_tx_pkg: shared state encoding and line levels for nibble_serial_tx.
package nibble_tx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
endpackage

// File: rtl/tx_shift_reg.sv
// tx_shift_reg: load/rotate register holding the word being sent.
// The word_xor port exists only when NIBBLE_TX_PARITY_EN is defined.
module tx_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             bit0
`ifdef NIBBLE_TX_PARITY_EN
    ,
    output logic             word_xor
`endif
);
    logic [WIDTH-1:0] q;
    // Rotating rather than shifting keeps the word intact for the parity bit.
    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else if (load) q <= din;
        else if (shift) q <= (q >> 1) | (q << (WIDTH - 1));
    end
    assign bit0 = q[0];
`ifdef NIBBLE_TX_PARITY_EN
    assign word_xor = ^q;
`endif
endmodule

// File: rtl/nibble_serial_tx.sv
// nibble_serial_tx: framed parallel-in serial-out transmitter (start, LSB-first data, stop).
// Defining NIBBLE_TX_PARITY_EN inserts an even-parity bit between data and stop.
module nibble_serial_tx
    import nibble_tx_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int BIT_TICKS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_line,
    output logic             busy,
    output logic             done
);
    localparam int TW = BIT_TICKS > 1 ? $clog2(BIT_TICKS) : 1;
    localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    tx_state_e state, state_n;
    logic [TW-1:0] tick, tick_n;
    logic [BW-1:0] bit_cnt, bit_n;
    logic load, shift, tick_end, data_bit, line_n;
`ifdef NIBBLE_TX_PARITY_EN
    logic parity_bit;
`endif
    tx_shift_reg #(.WIDTH(WIDTH)) u_sr (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift    (shift),
        .din      (tx_data),
        .bit0     (data_bit)
`ifdef NIBBLE_TX_PARITY_EN
        ,
        .word_xor (parity_bit)
`endif
    );
    assign tick_end = tick == TW'(BIT_TICKS - 1);
    always_comb begin
        state_n = state;
        bit_n   = bit_cnt;
        load    = 1'b0;
        shift   = 1'b0;
        tick_n  = (state == IDLE || tick_end) ? '0 : tick + 1'b1;
        case (state)
            IDLE:  if (tx_valid && tx_ready) begin
                state_n = START;
                load    = 1'b1;
            end
            START: if (tick_end) begin
                state_n = DATA;
                bit_n   = '0;
                shift   = 1'b1;
            end
            DATA:  if (tick_end) begin
                if (bit_cnt == BW'(WIDTH - 1)) begin
`ifdef NIBBLE_TX_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
                end else begin
                    bit_n = bit_cnt + 1'b1;
                    shift = 1'b1;
                end
            end
`ifdef NIBBLE_TX_PARITY_EN
            PARITY: if (tick_end) state_n = STOP;
`endif
            STOP:  if (tick_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Each data bit is captured from bit 0 on the same edge that rotates it away.
        line_n = (state_n == START) ? START_LEVEL : (state_n == IDLE) ? IDLE_LEVEL : STOP_LEVEL;
`ifdef NIBBLE_TX_PARITY_EN
        if (state_n == PARITY) line_n = parity_bit;
`endif
        if (state_n == DATA) line_n = shift ? data_bit : tx_line;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tick     <= '0;
            bit_cnt  <= '0;
            tx_line  <= IDLE_LEVEL;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            tick     <= tick_n;
            bit_cnt  <= bit_n;
            tx_line  <= line_n;
            tx_ready <= state_n == IDLE;
            busy     <= state_n != IDLE;
            done     <= state_n == STOP && tick_n == TW'(BIT_TICKS - 1);
        end
    end
endmodule

// File: tb/tb_nibble_serial_tx.sv
// tb_nibble_serial_tx: directed scoreboard bench for nibble_serial_tx (default and 1x1 configurations).
module tb_nibble_serial_tx;
    localparam int W  = 4;
    localparam int BT = 4;
`ifdef NIBBLE_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB = W + 2 + P;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [W-1:0] tx_data = '0;
    logic tx_valid = 1'b0;
    logic tx_ready, tx_line, busy, done;
    logic [0:0] s_data = 1'b0;
    logic s_valid = 1'b0;
    logic s_ready, s_line, s_busy, s_done;
    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    nibble_serial_tx #(.WIDTH(W), .BIT_TICKS(BT)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_line(tx_line), .busy(busy), .done(done)
    );

    nibble_serial_tx #(.WIDTH(1), .BIT_TICKS(1)) dut_small (
        .clk(clk), .reset(reset), .tx_data(s_data), .tx_valid(s_valid),
        .tx_ready(s_ready), .tx_line(s_line), .busy(s_busy), .done(s_done)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [W-1:0] w);
        exp_q.push_back(1'b0);
        for (int i = 0; i < W; i++) exp_q.push_back(w[i]);
        if (P == 1) exp_q.push_back(^w);
        exp_q.push_back(1'b1);
    endtask

    task automatic idle_check(input string tag);
        check({tag, "_line"}, tx_line, 1);
        check({tag, "_ready"}, tx_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // Called at the negedge of the first frame cycle; returns at the negedge of the last one.
    task automatic run_frame(input string tag);
        bit b;
        for (int k = 0; k < NB; k++) begin
            check({tag, "_queue"}, exp_q.size() != 0, 1);
            b = exp_q.size() != 0 ? exp_q.pop_front() : 1'b1;
            for (int t = 0; t < BT; t++) begin
                check({tag, "_line"}, tx_line, b);
                check({tag, "_busy"}, busy, 1);
                check({tag, "_ready"}, tx_ready, 0);
                check({tag, "_done"}, done, (k == NB - 1 && t == BT - 1));
                if (!(k == NB - 1 && t == BT - 1)) @(negedge clk);
            end
        end
    endtask

    initial begin
        logic [3:0] s_exp [0:3];
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle_check("reset");
        check("small_reset_line", s_line, 1);
        check("small_reset_ready", s_ready, 1);

        // 4'hA frame; tx_data changes right after accept
        tx_data = 4'hA; tx_valid = 1'b1; push_frame(4'hA);
        @(negedge clk);
        tx_valid = 1'b0; tx_data = 4'h0;
        run_frame("frame_a");
        @(negedge clk);
        idle_check("after_a");

`ifdef NIBBLE_TX_PARITY_EN
        tx_data = 4'h7; tx_valid = 1'b1; push_frame(4'h7);
        @(negedge clk);
        tx_valid = 1'b0;
        run_frame("parity_7");
        @(negedge clk);
        tx_data = 4'h3; tx_valid = 1'b1; push_frame(4'h3);
        @(negedge clk);
        tx_valid = 1'b0;
        run_frame("parity_3");
        @(negedge clk);
        idle_check("after_parity");
`endif

        // back-to-back with tx_valid held high
        tx_data = 4'h1; tx_valid = 1'b1; push_frame(4'h1); push_frame(4'hF);
        @(negedge clk);
        tx_data = 4'hF;
        run_frame("b2b_1");
        @(negedge clk);
        check("b2b_gap_line", tx_line, 1);
        check("b2b_gap_ready", tx_ready, 1);
        check("b2b_gap_busy", busy, 0);
        @(negedge clk);
        tx_valid = 1'b0;
        run_frame("b2b_2");
        @(negedge clk);
        idle_check("after_b2b");

        // tx_valid pulsed while busy is dropped
        tx_data = 4'h6; tx_valid = 1'b1; push_frame(4'h6);
        @(negedge clk);
        tx_valid = 1'b0;
        fork
            run_frame("busy_ignore");
            begin
                repeat (5) @(negedge clk);
                tx_data = 4'h5; tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            idle_check("ignored_idle");
        end
        check("queue_empty", exp_q.size(), 0);

        // reset mid-frame
        tx_data = 4'h9; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("abort_busy", busy, 1);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            idle_check("in_reset");
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            idle_check("post_reset");
        end

        // WIDTH=1, BIT_TICKS=1 instance
        s_exp[0] = 4'h0; s_exp[1] = 4'h1; s_exp[2] = 4'h1; s_exp[3] = 4'h1;
        s_data = 1'b1; s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        for (int i = 0; i < 3 + P; i++) begin
            check("small_line", s_line, s_exp[i]);
            check("small_done", s_done, (i == 2 + P));
            check("small_busy", s_busy, 1);
            @(negedge clk);
        end
        check("small_idle_line", s_line, 1);
        check("small_idle_ready", s_ready, 1);
        check("small_idle_done", s_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
